// File: rtl/spec_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spec_rd_arbiter
// Brief   : Two-port burst arbiter for the FFT spectrum read port, with an
//           owner-tag FIFO that routes returning data to the issuing port.
// Revision: 1.0 - initial release
// ============================================================================
module spec_rd_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int MAX_OUT  = 4,
    parameter int HOLD_MAX = 256
) (
    input  logic              clk_50m,
    input  logic              rst_n,

    input  logic              s0_req,
    output logic              s0_gnt,
    input  logic              s0_rd_en,
    input  logic [ADDR_W-1:0] s0_rd_addr,
    output logic              s0_rd_ready,
    output logic [DATA_W-1:0] s0_rd_data,
    output logic              s0_rd_data_valid,

    input  logic              s1_req,
    output logic              s1_gnt,
    input  logic              s1_rd_en,
    input  logic [ADDR_W-1:0] s1_rd_addr,
    output logic              s1_rd_ready,
    output logic [DATA_W-1:0] s1_rd_data,
    output logic              s1_rd_data_valid,

    output logic              m_rd_en,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rd_data_valid,

    output logic [1:0]        err_flags
);

    localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0]  C_FIFO_DEPTH = CNT_W'(MAX_OUT);
    localparam logic [HOLD_W-1:0] C_HOLD_LAST  = HOLD_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_gnt0;
    logic               r_gnt1;
    logic [HOLD_W-1:0]  r_hold;

    logic               r_tag [MAX_OUT];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;

    logic [ADDR_W-1:0]  r_last_addr;
    logic [1:0]         r_err;

    logic               w_rdy0;
    logic               w_rdy1;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_push;
    logic               w_pop;
    logic               w_head;
    logic [CNT_W-1:0]   w_count_nxt;

    // Ready uses the registered full flag, so a pop cannot free a slot
    // for a push in the same cycle.
    assign w_rdy0 = r_gnt0 & ~r_full;
    assign w_rdy1 = r_gnt1 & ~r_full;
    assign w_acc0 = s0_rd_en & w_rdy0;
    assign w_acc1 = s1_rd_en & w_rdy1;
    assign w_push = w_acc0 | w_acc1;
    assign w_pop  = m_rd_data_valid & ~r_empty;
    assign w_head = r_tag[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Grant state machine; gnt outputs are registered alongside the state.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s0_req) begin
                        r_state <= ST_GNT0;
                        r_gnt0  <= 1'b1;
                    end else if (s1_req) begin
                        r_state <= ST_GNT1;
                        r_gnt1  <= 1'b1;
                        r_hold  <= '0;
                    end
                end
                ST_GNT0: begin
                    if (!s0_req) begin
                        r_state <= ST_DRAIN;
                        r_gnt0  <= 1'b0;
                    end
                end
                ST_GNT1: begin
                    if (s0_req && (r_hold != C_HOLD_LAST)) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                    if (!s1_req || (s0_req && (r_hold == C_HOLD_LAST))) begin
                        r_state <= ST_DRAIN;
                        r_gnt1  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (r_empty && !w_push) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    // Owner-tag FIFO control; a tag of 1 marks a port 1 read.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_FIFO_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk_50m) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_acc1;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_last_addr <= '0;
        end else if (w_acc0) begin
            r_last_addr <= s0_rd_addr;
        end else if (w_acc1) begin
            r_last_addr <= s1_rd_addr;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_err <= 2'b00;
        end else begin
            r_err[0] <= r_err[0] | (s0_rd_en & ~r_gnt0) | (s1_rd_en & ~r_gnt1);
            r_err[1] <= r_err[1] | (m_rd_data_valid & r_empty);
        end
    end

    assign s0_gnt           = r_gnt0;
    assign s1_gnt           = r_gnt1;
    assign s0_rd_ready      = w_rdy0;
    assign s1_rd_ready      = w_rdy1;
    assign s0_rd_data       = m_rd_data;
    assign s1_rd_data       = m_rd_data;
    assign s0_rd_data_valid = w_pop & ~w_head;
    assign s1_rd_data_valid = w_pop &  w_head;

    assign m_rd_en   = w_push;
    assign m_rd_addr = w_acc0 ? s0_rd_addr : (w_acc1 ? s1_rd_addr : r_last_addr);
    assign err_flags = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spec_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spec_rd_arbiter
// Brief   : Randomised bench for spec_rd_arbiter with an FFT latency model
//           and a queue-based reference of grants and outstanding reads.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spec_rd_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int MAX_OUT  = 4;
    localparam int HOLD_MAX = 8;

    logic              clk_50m = 1'b0;
    logic              rst_n   = 1'b0;
    logic              s0_req = 1'b0, s0_rd_en = 1'b0;
    logic [ADDR_W-1:0] s0_rd_addr = '0;
    logic              s1_req = 1'b0, s1_rd_en = 1'b0;
    logic [ADDR_W-1:0] s1_rd_addr = '0;
    logic [DATA_W-1:0] m_rd_data = '0;
    logic              m_rd_data_valid = 1'b0;
    logic              s0_gnt, s0_rd_ready, s0_rd_data_valid;
    logic              s1_gnt, s1_rd_ready, s1_rd_data_valid;
    logic [DATA_W-1:0] s0_rd_data, s1_rd_data;
    logic              m_rd_en;
    logic [ADDR_W-1:0] m_rd_addr;
    logic [1:0]        err_flags;

    always #5 clk_50m = ~clk_50m;

    spec_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .HOLD_MAX(HOLD_MAX)
    ) u_dut (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .s0_req(s0_req), .s0_gnt(s0_gnt), .s0_rd_en(s0_rd_en), .s0_rd_addr(s0_rd_addr),
        .s0_rd_ready(s0_rd_ready), .s0_rd_data(s0_rd_data), .s0_rd_data_valid(s0_rd_data_valid),
        .s1_req(s1_req), .s1_gnt(s1_gnt), .s1_rd_en(s1_rd_en), .s1_rd_addr(s1_rd_addr),
        .s1_rd_ready(s1_rd_ready), .s1_rd_data(s1_rd_data), .s1_rd_data_valid(s1_rd_data_valid),
        .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data),
        .m_rd_data_valid(m_rd_data_valid), .err_flags(err_flags)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: owner (-1 none, 0, 1), drain flag, queue of outstanding reads.
    typedef struct packed { logic port; logic [ADDR_W-1:0] addr; } tag_t;
    tag_t              mq[$];
    int                own   = -1;
    bit                drain = 1'b0;
    int                hold  = 0;
    logic [1:0]        merr  = 2'b00;
    logic [ADDR_W-1:0] mlast = '0;

    // FFT environment: in-order pipe of issued reads with per-read latency.
    typedef struct { int due; logic [ADDR_W-1:0] addr; } rd_t;
    rd_t               pipe[$];
    int                lat      = 2;
    int                last_due = 0;
    bit                spur     = 1'b0;
    logic [DATA_W-1:0] mem [32];

    bit p_acc0, p_acc1;
    bit obs_men, obs_v0, obs_v1, obs_rdy0;
    int n_men, n_v0, n_v1, n_acc1, max_os, last_v0_cyc;

    task automatic clr_counts();
        n_men = 0; n_v0 = 0; n_v1 = 0; n_acc1 = 0; max_os = 0;
    endtask

    task automatic run_cycle();
        bit g0, g1, r0, r1, a0, a1, pop, hp;
        int sz, d;
        logic [ADDR_W-1:0] ea;
        m_rd_data_valid = 1'b0;
        m_rd_data       = DATA_W'($urandom);
        if (spur) begin
            m_rd_data_valid = 1'b1;
        end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            m_rd_data_valid = 1'b1;
            m_rd_data       = mem[pipe[0].addr];
            void'(pipe.pop_front());
        end
        #3;
        g0  = (own == 0);
        g1  = (own == 1);
        r0  = g0 && (mq.size() < MAX_OUT);
        r1  = g1 && (mq.size() < MAX_OUT);
        a0  = s0_rd_en && r0;
        a1  = s1_rd_en && r1;
        ea  = a0 ? s0_rd_addr : (a1 ? s1_rd_addr : mlast);
        pop = m_rd_data_valid && (mq.size() > 0);
        hp  = pop ? mq[0].port : 1'b0;
        check_eq("s0_gnt", s0_gnt, g0);
        check_eq("s1_gnt", s1_gnt, g1);
        check_eq("s0_rd_ready", s0_rd_ready, r0);
        check_eq("s1_rd_ready", s1_rd_ready, r1);
        check_eq("m_rd_en", m_rd_en, a0 | a1);
        check_eq("m_rd_addr", m_rd_addr, ea);
        check_eq("s0_rd_data_valid", s0_rd_data_valid, pop && !hp);
        check_eq("s1_rd_data_valid", s1_rd_data_valid, pop && hp);
        check_eq("err_flags", err_flags, merr);
        check_eq("s0_rd_data", s0_rd_data, m_rd_data);
        check_eq("s1_rd_data", s1_rd_data, m_rd_data);
        if (pop) check_eq("rd_data_value", s0_rd_data, mem[mq[0].addr]);

        obs_men  = m_rd_en;
        obs_v0   = s0_rd_data_valid;
        obs_v1   = s1_rd_data_valid;
        obs_rdy0 = s0_rd_ready;
        if (obs_men) n_men++;
        if (obs_v0) begin n_v0++; last_v0_cyc = cyc; end
        if (obs_v1) n_v1++;
        if (n_men - n_v0 - n_v1 > max_os) max_os = n_men - n_v0 - n_v1;
        if (m_rd_en) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pipe.push_back('{due: d, addr: m_rd_addr});
        end

        p_acc0 = a0;
        p_acc1 = a1;
        if (a1) n_acc1++;
        if (!rst_n) begin
            own = -1; drain = 1'b0; hold = 0; mq.delete(); merr = 2'b00; mlast = '0;
        end else begin
            if ((s0_rd_en && !g0) || (s1_rd_en && !g1)) merr[0] = 1'b1;
            if (m_rd_data_valid && mq.size() == 0) merr[1] = 1'b1;
            sz = mq.size();
            if (pop) void'(mq.pop_front());
            if (a0) mq.push_back('{port: 1'b0, addr: s0_rd_addr});
            if (a1) mq.push_back('{port: 1'b1, addr: s1_rd_addr});
            if (a0 || a1) mlast = ea;
            if (drain) begin
                if (sz == 0) drain = 1'b0;
            end else if (own < 0) begin
                if (s0_req) own = 0;
                else if (s1_req) begin own = 1; hold = 0; end
            end else if (own == 0) begin
                if (!s0_req) begin own = -1; drain = 1'b1; end
            end else begin
                if (!s1_req || (s0_req && hold == HOLD_MAX - 1)) begin
                    own = -1; drain = 1'b1;
                end else if (s0_req) begin
                    hold++;
                end
            end
        end
        cyc++;
        @(posedge clk_50m);
        #1;
    endtask

    task automatic idle_inputs();
        s0_req = 1'b0; s0_rd_en = 1'b0; s0_rd_addr = '0;
        s1_req = 1'b0; s1_rd_en = 1'b0; s1_rd_addr = '0;
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        idle_inputs();
        while (!(own < 0 && !drain && mq.size() == 0 && pipe.size() == 0) && n < budget) begin
            run_cycle();
            n++;
        end
        check_eq("drain_done", n < budget, 1);
    endtask

    task automatic wait_gnt(input int who, input int budget);
        int n = 0;
        while ((who == 0 ? s0_gnt : s1_gnt) !== 1'b1 && n < budget) begin
            s0_rd_en = 1'b0; s1_rd_en = 1'b0;
            run_cycle();
            n++;
        end
        check_eq("gnt_seen", (who == 0) ? s0_gnt : s1_gnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] addr;
        int n, k, n1, nacc, first_block;
        for (int i = 0; i < 32; i++) mem[i] = DATA_W'($urandom);
        clr_counts();
        last_v0_cyc = 0;

        // Reset
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk_50m); #1;
        repeat (3) run_cycle();
        rst_n = 1'b1;
        run_cycle();
        check_eq("rst_s0_gnt", s0_gnt, 0);
        check_eq("rst_s1_gnt", s1_gnt, 0);
        check_eq("rst_m_rd_addr", m_rd_addr, 0);
        check_eq("rst_err", err_flags, 0);

        // Single port 0 burst, addresses 0..31, latency 2
        clr_counts();
        lat = 2; addr = '0; n = 0; nacc = 0;
        s0_req = 1'b1;
        while (nacc < 32 && n < 300) begin
            s0_rd_en = (own == 0); s0_rd_addr = addr;
            run_cycle();
            if (p_acc0) begin addr++; nacc++; end
            n++;
        end
        wait_drained(100);
        check_eq("burst_m_rd_en_count", n_men, 32);
        check_eq("burst_s0_valid_count", n_v0, 32);
        check_eq("burst_s1_valid_count", n_v1, 0);
        check_eq("burst_err", err_flags, 0);

        // Simultaneous request
        clr_counts();
        lat = 3;
        s0_req = 1'b1; s1_req = 1'b1;
        run_cycle();
        check_eq("sim_s0_gnt", s0_gnt, 1);
        check_eq("sim_s1_gnt_low", s1_gnt, 0);
        for (int i = 0; i < 6; i++) begin
            s0_rd_en = 1'b1; s0_rd_addr = ADDR_W'($urandom);
            run_cycle();
        end
        s0_rd_en = 1'b0; s0_req = 1'b0;
        n = 0;
        while (s1_gnt !== 1'b1 && n < 100) begin run_cycle(); n++; end
        check_eq("sim_gap_after_drain", cyc - last_v0_cyc, 3);
        check_eq("sim_s0_valid_count", n_v0, 6);
        for (int i = 0; i < 4; i++) begin
            s1_rd_en = (own == 1); s1_rd_addr = ADDR_W'($urandom);
            run_cycle();
        end
        wait_drained(100);
        check_eq("sim_s1_valid_count", n_v1, n_acc1);

        // Preemption with HOLD_MAX = 8
        clr_counts();
        lat = 3;
        s1_req = 1'b1;
        wait_gnt(1, 20);
        for (int i = 0; i < 5; i++) begin
            s1_rd_en = (own == 1); s1_rd_addr = ADDR_W'($urandom);
            run_cycle();
        end
        s0_req = 1'b1; n1 = 0; k = 0;
        while (s1_gnt === 1'b1 && k < 40) begin
            n1++; k++;
            s1_rd_en = (own == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            s1_rd_addr = ADDR_W'($urandom);
            run_cycle();
        end
        check_eq("preempt_gnt1_cycles", n1, 8);
        s1_rd_en = 1'b0;
        wait_gnt(0, 30);
        check_eq("preempt_s1_data_delivered", n_v1, n_acc1);
        for (int i = 0; i < 3; i++) begin
            s0_rd_en = (own == 0); s0_rd_addr = ADDR_W'($urandom);
            run_cycle();
        end
        wait_drained(150);

        // Backpressure, latency 10
        clr_counts();
        lat = 10; addr = '0; nacc = 0; first_block = -1;
        s0_req = 1'b1;
        wait_gnt(0, 20);
        for (int i = 0; i < 80; i++) begin
            s0_rd_en = 1'b1; s0_rd_addr = addr;
            run_cycle();
            if (p_acc0) begin addr++; nacc++; end
            if (!obs_rdy0 && first_block < 0) first_block = nacc;
        end
        wait_drained(100);
        check_eq("bp_accepts_before_block", first_block, 4);
        check_eq("bp_outstanding_le_max", max_os <= MAX_OUT, 1);
        check_eq("bp_no_loss", n_v0, n_men);

        // Randomised mixed traffic
        clr_counts();
        for (int i = 0; i < 500; i++) begin
            lat = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) s0_req = ~s0_req;
            if ($urandom_range(0, 5) == 0) s1_req = ~s1_req;
            s0_rd_en = (own == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            s1_rd_en = (own == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            s0_rd_addr = ADDR_W'($urandom);
            s1_rd_addr = ADDR_W'($urandom);
            run_cycle();
        end
        wait_drained(200);
        check_eq("rand_no_loss", n_v0 + n_v1, n_men);
        check_eq("rand_err", err_flags, 0);

        // Errors: ungranted strobe, then spurious return while idle
        lat = 2;
        s0_req = 1'b1;
        wait_gnt(0, 20);
        s1_rd_en = 1'b1; s1_rd_addr = 5'd7;
        run_cycle();
        check_eq("err0_no_m_rd_en", obs_men, 0);
        s1_rd_en = 1'b0;
        repeat (5) run_cycle();
        check_eq("err0_sticky", err_flags[0], 1);
        wait_drained(50);
        spur = 1'b1;
        run_cycle();
        spur = 1'b0;
        check_eq("spur_no_valid", {obs_v0, obs_v1}, 0);
        run_cycle();
        check_eq("err_both", err_flags, 2'b11);

        // Reset mid-burst with 3 reads outstanding
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        lat = 10;
        s0_req = 1'b1;
        wait_gnt(0, 20);
        for (int i = 0; i < 3; i++) begin
            s0_rd_en = 1'b1; s0_rd_addr = ADDR_W'(i + 3);
            run_cycle();
        end
        s0_rd_en = 1'b0;
        clr_counts();
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        check_eq("mid_rst_s0_gnt", s0_gnt, 0);
        check_eq("mid_rst_s1_gnt", s1_gnt, 0);
        check_eq("mid_rst_err", err_flags, 0);
        s0_req = 1'b0;
        repeat (15) run_cycle();
        check_eq("late_valid_not_routed", n_v0 + n_v1, 0);
        check_eq("late_valid_err1", err_flags, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
